// File: rtl/cmpt_rf_wr_arb.sv
// Register-file write-port arbiter for the ALU, MUL and Shifter write-backs.
// Each unit has its own small FIFO, drained round-robin into a registered write port; a pending-write scoreboard drives the issue stall.
module cmpt_rf_wr_arb #(
  parameter int DW    = 32,
  parameter int AW    = 4,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps_alu_wv,
  input  logic [AW-1:0] ps_alu_wa,
  input  logic [DW-1:0] ps_alu_wd,
  input  logic          ps_mul_wv,
  input  logic [AW-1:0] ps_mul_wa,
  input  logic [DW-1:0] ps_mul_wd,
  input  logic          ps_shf_wv,
  input  logic [AW-1:0] ps_shf_wa,
  input  logic [DW-1:0] ps_shf_wd,
  output logic          ps_alu_rdy,
  output logic          ps_mul_rdy,
  output logic          ps_shf_rdy,
  input  logic          ps_chk_en,
  input  logic [AW-1:0] ps_xb_rd_a0,
  input  logic [AW-1:0] ps_xb_raddy,
  input  logic [AW-1:0] ps_xb_wrt_a,
  output logic          ps_rf_we,
  output logic [AW-1:0] ps_rf_wa,
  output logic [DW-1:0] ps_rf_wd,
  output logic [1:0]    ps_rf_src,
  output logic          ps_hzd_stl,
  output logic          ps_arb_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MUL = 2'd1,
    SRC_SHF = 2'd2
  } src_e;

  function automatic src_e nxt_src(input src_e s);
    case (s)
      SRC_ALU: return SRC_MUL;
      SRC_MUL: return SRC_SHF;
      default: return SRC_ALU;
    endcase
  endfunction

  function automatic logic addr_hit(input logic [AW-1:0] a, input logic [AW-1:0] r0,
                                    input logic [AW-1:0] r1, input logic [AW-1:0] w);
    return (a == r0) || (a == r1) || (a == w);
  endfunction

  logic [2:0]    push_v;
  logic [AW-1:0] push_a [3];
  logic [DW-1:0] push_d [3];

  logic [AW-1:0] fa [3][DEPTH];
  logic [DW-1:0] fd [3][DEPTH];
  logic [PW-1:0] wp [3];
  logic [PW-1:0] rp [3];
  logic [CW-1:0] cnt [3];

  logic [2:0]    full, nempty, rdy, push, pop;
  src_e          rr, grant_s, cand;
  logic          grant_v;
  logic [AW-1:0] head_a;
  logic [DW-1:0] head_d;
  logic          hit;
  logic [PW-1:0] ofs;

  always_comb begin
    push_v    = {ps_shf_wv, ps_mul_wv, ps_alu_wv};
    push_a[0] = ps_alu_wa;
    push_a[1] = ps_mul_wa;
    push_a[2] = ps_shf_wa;
    push_d[0] = ps_alu_wd;
    push_d[1] = ps_mul_wd;
    push_d[2] = ps_shf_wd;
  end

  // Ready is taken from occupancy alone, so a same-cycle pop never frees room for a push.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      full[i]   = (cnt[i] == CW'(DEPTH));
      nempty[i] = (cnt[i] != '0);
      rdy[i]    = !full[i];
      push[i]   = push_v[i] && rdy[i];
    end
  end

  assign ps_alu_rdy = rdy[0];
  assign ps_mul_rdy = rdy[1];
  assign ps_shf_rdy = rdy[2];

  always_comb begin
    grant_v = 1'b0;
    grant_s = rr;
    cand    = nxt_src(rr);
    for (int unsigned k = 0; k < 3; k++) begin
      if (!grant_v && nempty[cand]) begin
        grant_v = 1'b1;
        grant_s = cand;
      end
      cand = nxt_src(cand);
    end
    pop = '0;
    if (grant_v) pop[grant_s] = 1'b1;
    head_a = fa[grant_s][rp[grant_s]];
    head_d = fd[grant_s][rp[grant_s]];
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (push[i]) begin
        fa[i][wp[i]] <= push_a[i];
        fd[i][wp[i]] <= push_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 3; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        cnt[i] <= '0;
      end
      rr         <= SRC_SHF;
      ps_rf_we   <= 1'b0;
      ps_rf_wa   <= '0;
      ps_rf_wd   <= '0;
      ps_rf_src  <= '0;
      ps_arb_ovf <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (push[i]) wp[i] <= wp[i] + 1'b1;
        if (pop[i])  rp[i] <= rp[i] + 1'b1;
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
      if (|(push_v & ~rdy)) ps_arb_ovf <= 1'b1;
      ps_rf_we <= grant_v;
      if (grant_v) begin
        rr        <= grant_s;
        ps_rf_wa  <= head_a;
        ps_rf_wd  <= head_d;
        ps_rf_src <= grant_s;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    hit = 1'b0;
    ofs = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        ofs = PW'(j) - rp[i];
        if ({1'b0, ofs} < cnt[i] && addr_hit(fa[i][j], ps_xb_rd_a0, ps_xb_raddy, ps_xb_wrt_a))
          hit = 1'b1;
      end
      if (push[i] && addr_hit(push_a[i], ps_xb_rd_a0, ps_xb_raddy, ps_xb_wrt_a))
        hit = 1'b1;
    end
    if (ps_rf_we && addr_hit(ps_rf_wa, ps_xb_rd_a0, ps_xb_raddy, ps_xb_wrt_a))
      hit = 1'b1;
    ps_hzd_stl = ps_chk_en && hit;
  end

endmodule

// File: tb/tb_cmpt_rf_wr_arb.sv
// Directed bench for cmpt_rf_wr_arb: latency, round-robin order, overflow, hazard stall and async reset.
module tb_cmpt_rf_wr_arb;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ps_alu_wv, ps_mul_wv, ps_shf_wv;
  logic [AW-1:0] ps_alu_wa, ps_mul_wa, ps_shf_wa;
  logic [DW-1:0] ps_alu_wd, ps_mul_wd, ps_shf_wd;
  logic          ps_alu_rdy, ps_mul_rdy, ps_shf_rdy;
  logic          ps_chk_en;
  logic [AW-1:0] ps_xb_rd_a0, ps_xb_raddy, ps_xb_wrt_a;
  logic          ps_rf_we;
  logic [AW-1:0] ps_rf_wa;
  logic [DW-1:0] ps_rf_wd;
  logic [1:0]    ps_rf_src;
  logic          ps_hzd_stl, ps_arb_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmpt_rf_wr_arb #(.DW(DW), .AW(AW), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .ps_alu_wv(ps_alu_wv), .ps_alu_wa(ps_alu_wa), .ps_alu_wd(ps_alu_wd),
    .ps_mul_wv(ps_mul_wv), .ps_mul_wa(ps_mul_wa), .ps_mul_wd(ps_mul_wd),
    .ps_shf_wv(ps_shf_wv), .ps_shf_wa(ps_shf_wa), .ps_shf_wd(ps_shf_wd),
    .ps_alu_rdy(ps_alu_rdy), .ps_mul_rdy(ps_mul_rdy), .ps_shf_rdy(ps_shf_rdy),
    .ps_chk_en(ps_chk_en), .ps_xb_rd_a0(ps_xb_rd_a0), .ps_xb_raddy(ps_xb_raddy),
    .ps_xb_wrt_a(ps_xb_wrt_a),
    .ps_rf_we(ps_rf_we), .ps_rf_wa(ps_rf_wa), .ps_rf_wd(ps_rf_wd), .ps_rf_src(ps_rf_src),
    .ps_hzd_stl(ps_hzd_stl), .ps_arb_ovf(ps_arb_ovf)
  );

  task automatic clear_in();
    ps_alu_wv = 0; ps_alu_wa = '0; ps_alu_wd = '0;
    ps_mul_wv = 0; ps_mul_wa = '0; ps_mul_wd = '0;
    ps_shf_wv = 0; ps_shf_wa = '0; ps_shf_wd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_in();
    ps_chk_en = 0; ps_xb_rd_a0 = '0; ps_xb_raddy = '0; ps_xb_wrt_a = '0;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ps_rf_we !== 0 || ps_rf_wa !== 0 || ps_rf_wd !== 0 || ps_rf_src !== 0) begin
      errors++;
      $display("FAIL reset_out: we=%0b wa=%0d wd=%h src=%0d, want all 0", ps_rf_we, ps_rf_wa, ps_rf_wd, ps_rf_src);
    end
    checks++;
    if ({ps_alu_rdy, ps_mul_rdy, ps_shf_rdy} !== 3'b111 || ps_arb_ovf !== 0 || ps_hzd_stl !== 0) begin
      errors++;
      $display("FAIL reset_flags: rdy=%b ovf=%b stl=%b, want 111 0 0", {ps_alu_rdy, ps_mul_rdy, ps_shf_rdy}, ps_arb_ovf, ps_hzd_stl);
    end
  endtask

  task automatic test_latency();
    do_reset();
    ps_alu_wv = 1; ps_alu_wa = 4'd3; ps_alu_wd = 32'hA5A5A5A5;
    tick();
    clear_in();
    checks++;
    if (ps_rf_we !== 0) begin errors++; $display("FAIL lat_early: we=%b want 0", ps_rf_we); end
    tick();
    checks++;
    if (ps_rf_we !== 1 || ps_rf_wa !== 4'd3 || ps_rf_wd !== 32'hA5A5A5A5 || ps_rf_src !== 2'd0) begin
      errors++;
      $display("FAIL lat_write: we=%b wa=%0d wd=%h src=%0d, want 1 3 a5a5a5a5 0", ps_rf_we, ps_rf_wa, ps_rf_wd, ps_rf_src);
    end
    tick();
    checks++;
    if (ps_rf_we !== 0 || ps_rf_wa !== 4'd3) begin
      errors++; $display("FAIL lat_idle: we=%b wa=%0d, want 0 3 (held)", ps_rf_we, ps_rf_wa);
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_a [6];
    logic [1:0]    exp_s [6];
    exp_a = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    do_reset();
    ps_alu_wv = 1; ps_alu_wa = 4'd1; ps_alu_wd = 32'h11;
    ps_mul_wv = 1; ps_mul_wa = 4'd2; ps_mul_wd = 32'h22;
    ps_shf_wv = 1; ps_shf_wa = 4'd3; ps_shf_wd = 32'h33;
    tick();
    clear_in();
    for (int n = 0; n < 6; n++) begin
      if (n == 2) begin
        ps_alu_wv = 1; ps_alu_wa = 4'd4; ps_alu_wd = 32'h44;
        ps_mul_wv = 1; ps_mul_wa = 4'd5; ps_mul_wd = 32'h55;
        ps_shf_wv = 1; ps_shf_wa = 4'd6; ps_shf_wd = 32'h66;
      end
      tick();
      clear_in();
      checks++;
      if (ps_rf_we !== 1 || ps_rf_src !== exp_s[n] || ps_rf_wa !== exp_a[n] || ps_rf_wd !== 32'({exp_a[n], exp_a[n]})) begin
        errors++;
        $display("FAIL rr_%0d: we=%b src=%0d wa=%0d wd=%h, want 1 %0d %0d", n, ps_rf_we, ps_rf_src, ps_rf_wa, ps_rf_wd, exp_s[n], exp_a[n]);
      end
    end
    tick();
    checks++;
    if (ps_rf_we !== 0) begin errors++; $display("FAIL rr_drain: we=%b want 0", ps_rf_we); end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] exp_a [4];
    logic [1:0]    exp_s [4];
    exp_a = '{4'd9, 4'd11, 4'd12, 4'd0};
    exp_s = '{2'd0, 2'd1, 2'd1, 2'd0};
    do_reset();
    ps_mul_wv = 1; ps_mul_wa = 4'd8; ps_mul_wd = 32'h8;
    tick();
    ps_alu_wv = 1; ps_alu_wa = 4'd9;  ps_alu_wd = 32'h9;
    ps_shf_wv = 1; ps_shf_wa = 4'd10; ps_shf_wd = 32'h10;
    ps_mul_wv = 1; ps_mul_wa = 4'd11; ps_mul_wd = 32'h11;
    tick();
    clear_in();
    checks++;
    if (ps_rf_we !== 1 || ps_rf_src !== 2'd1 || ps_rf_wa !== 4'd8) begin
      errors++; $display("FAIL ovf_w0: we=%b src=%0d wa=%0d, want 1 1 8", ps_rf_we, ps_rf_src, ps_rf_wa);
    end
    ps_mul_wv = 1; ps_mul_wa = 4'd12; ps_mul_wd = 32'h12;
    tick();
    clear_in();
    checks++;
    if (ps_rf_src !== 2'd2 || ps_rf_wa !== 4'd10 || ps_arb_ovf !== 0) begin
      errors++; $display("FAIL ovf_w1: src=%0d wa=%0d ovf=%b, want 2 10 0", ps_rf_src, ps_rf_wa, ps_arb_ovf);
    end
    ps_mul_wv = 1; ps_mul_wa = 4'd13; ps_mul_wd = 32'h13;
    #1;
    checks++;
    if (ps_mul_rdy !== 0 || ps_alu_rdy !== 1) begin
      errors++; $display("FAIL ovf_rdy: mul_rdy=%b alu_rdy=%b, want 0 1", ps_mul_rdy, ps_alu_rdy);
    end
    for (int n = 0; n < 4; n++) begin
      tick();
      clear_in();
      checks++;
      if (ps_arb_ovf !== 1) begin errors++; $display("FAIL ovf_sticky_%0d: ovf=%b want 1", n, ps_arb_ovf); end
      checks++;
      if (n < 3 && (ps_rf_we !== 1 || ps_rf_src !== exp_s[n] || ps_rf_wa !== exp_a[n])) begin
        errors++;
        $display("FAIL ovf_seq_%0d: we=%b src=%0d wa=%0d, want 1 %0d %0d", n, ps_rf_we, ps_rf_src, ps_rf_wa, exp_s[n], exp_a[n]);
      end else if (n == 3 && ps_rf_we !== 0) begin
        errors++; $display("FAIL ovf_dropped: we=%b wa=%0d, want we 0", ps_rf_we, ps_rf_wa);
      end
    end
    do_reset();
    checks++;
    if (ps_arb_ovf !== 0) begin errors++; $display("FAIL ovf_clear: ovf=%b want 0", ps_arb_ovf); end
  endtask

  task automatic test_hazard_raw();
    do_reset();
    ps_chk_en = 1; ps_xb_rd_a0 = 4'd9; ps_xb_raddy = 4'd5; ps_xb_wrt_a = 4'd10;
    #1;
    checks++;
    if (ps_hzd_stl !== 0) begin errors++; $display("FAIL raw_none: stl=%b want 0", ps_hzd_stl); end
    ps_shf_wv = 1; ps_shf_wa = 4'd5; ps_shf_wd = 32'h5;
    #1;
    checks++;
    if (ps_hzd_stl !== 1) begin errors++; $display("FAIL raw_push: stl=%b want 1", ps_hzd_stl); end
    tick();
    clear_in();
    checks++;
    if (ps_hzd_stl !== 1 || ps_rf_we !== 0) begin
      errors++; $display("FAIL raw_fifo: stl=%b we=%b, want 1 0", ps_hzd_stl, ps_rf_we);
    end
    tick();
    checks++;
    if (ps_hzd_stl !== 1 || ps_rf_we !== 1 || ps_rf_wa !== 4'd5 || ps_rf_src !== 2'd2) begin
      errors++; $display("FAIL raw_outreg: stl=%b we=%b wa=%0d src=%0d, want 1 1 5 2", ps_hzd_stl, ps_rf_we, ps_rf_wa, ps_rf_src);
    end
    ps_chk_en = 0;
    #1;
    checks++;
    if (ps_hzd_stl !== 0) begin errors++; $display("FAIL raw_chk_off: stl=%b want 0", ps_hzd_stl); end
    ps_chk_en = 1;
    tick();
    checks++;
    if (ps_hzd_stl !== 0 || ps_rf_we !== 0) begin
      errors++; $display("FAIL raw_release: stl=%b we=%b, want 0 0", ps_hzd_stl, ps_rf_we);
    end
    ps_chk_en = 0;
  endtask

  task automatic test_hazard_waw();
    do_reset();
    ps_chk_en = 1; ps_xb_rd_a0 = 4'd1; ps_xb_raddy = 4'd2; ps_xb_wrt_a = 4'd7;
    #1;
    checks++;
    if (ps_hzd_stl !== 0) begin errors++; $display("FAIL waw_none: stl=%b want 0", ps_hzd_stl); end
    ps_alu_wv = 1; ps_alu_wa = 4'd7; ps_alu_wd = 32'h77;
    #1;
    checks++;
    if (ps_hzd_stl !== 1) begin errors++; $display("FAIL waw_push: stl=%b want 1", ps_hzd_stl); end
    tick();
    clear_in();
    ps_xb_wrt_a = 4'd0;
    tick();
    checks++;
    if (ps_hzd_stl !== 0 || ps_rf_we !== 1) begin
      errors++; $display("FAIL waw_other: stl=%b we=%b, want 0 1", ps_hzd_stl, ps_rf_we);
    end
    ps_chk_en = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    ps_alu_wv = 1; ps_alu_wa = 4'd12; ps_alu_wd = 32'hC;
    ps_mul_wv = 1; ps_mul_wa = 4'd13; ps_mul_wd = 32'hD;
    ps_shf_wv = 1; ps_shf_wa = 4'd14; ps_shf_wd = 32'hE;
    tick();
    clear_in();
    tick();
    checks++;
    if (ps_rf_we !== 1 || ps_rf_wa !== 4'd12) begin
      errors++; $display("FAIL ares_pre: we=%b wa=%0d, want 1 12", ps_rf_we, ps_rf_wa);
    end
    #2 rst = 0;
    #1;
    checks++;
    if (ps_rf_we !== 0 || ps_rf_wa !== 0 || ps_rf_wd !== 0 || ps_rf_src !== 0) begin
      errors++; $display("FAIL ares_now: we=%b wa=%0d wd=%h src=%0d, want all 0", ps_rf_we, ps_rf_wa, ps_rf_wd, ps_rf_src);
    end
    #2 rst = 1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (ps_rf_we !== 0) begin errors++; $display("FAIL ares_after_%0d: we=%b want 0", n, ps_rf_we); end
    end
  endtask

  initial begin
    rst = 0;
    clear_in();
    ps_chk_en = 0; ps_xb_rd_a0 = '0; ps_xb_raddy = '0; ps_xb_wrt_a = '0;
    test_reset();
    test_latency();
    test_round_robin();
    test_overflow();
    test_hazard_raw();
    test_hazard_waw();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
